// File: rtl/tiny_cpu_gen2_if.sv
// rtl/tiny_cpu_gen2_if.sv - instruction/result bus for tiny_cpu_gen2
interface tiny_cpu_gen2_if #(
    parameter int W    = 8,
    parameter int NREG = 4
);
    localparam int RA = $clog2(NREG);
    localparam int IW = 4 + 2 * RA + W;

    logic [IW-1:0] In;
    logic          InValid;
    logic          InReady;
    logic [W-1:0]  Result;
    logic          ResultValid;
    logic          Zero;
    logic          Carry;
    logic          Busy;

    modport master (
        output In, InValid,
        input  InReady, Result, ResultValid, Zero, Carry, Busy
    );

    modport slave (
        input  In, InValid,
        output InReady, Result, ResultValid, Zero, Carry, Busy
    );
endinterface

// File: rtl/tiny_cpu_gen2.sv
// rtl/tiny_cpu_gen2.sv - three-cycle accumulator-style CPU core (IDLE/EXEC/WB)
module tiny_cpu_gen2 #(
    parameter int W    = 8,
    parameter int NREG = 4
) (
    input  logic             Clk,
    input  logic             Clear,
    tiny_cpu_gen2_if.slave   bus
);
    localparam int RA = $clog2(NREG);
    localparam int IW = 4 + 2 * RA + W;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t          state;
    logic [IW-1:0]   ir;
    logic [W-1:0]    r [NREG];
    logic [W-1:0]    tmp_res;
    logic            tmp_c;
    logic            tmp_z;
    logic [W-1:0]    result_q;
    logic            result_valid_q;
    logic            zero_q;
    logic            carry_q;

    logic [3:0]      op;
    logic [RA-1:0]   rd;
    logic [RA-1:0]   rs;
    logic [W-1:0]    imm;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    alu_res;
    logic            alu_c;

    assign op  = ir[IW-1 -: 4];
    assign rd  = ir[IW-5 -: RA];
    assign rs  = ir[IW-5-RA -: RA];
    assign imm = ir[W-1:0];
    assign a   = r[rd];
    assign b   = r[rs];

    // Flag-preserving default: alu_c carries the current Carry unless the opcode defines one.
    always_comb begin
        alu_res = a;
        alu_c   = carry_q;
        case (op)
            4'd1:        alu_res = imm;
            4'd2:        alu_res = b;
            4'd3:        {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
            4'd4:        {alu_c, alu_res} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_q};
            4'd5, 4'd13: begin
                alu_res = a - b;
                alu_c   = (a < b);
            end
            4'd6:        alu_res = a & b;
            4'd7:        alu_res = a | b;
            4'd8:        alu_res = a ^ b;
            4'd9:        alu_res = ~(a & b);
            4'd10: begin
                alu_res = {a[W-2:0], 1'b0};
                alu_c   = a[W-1];
            end
            4'd11: begin
                alu_res = {1'b0, a[W-1:1]};
                alu_c   = a[0];
            end
            4'd12:       alu_res = ~a;
            4'd14:       alu_res = b;
            default:     alu_res = a;
        endcase
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state          <= IDLE;
            ir             <= '0;
            tmp_res        <= '0;
            tmp_c          <= 1'b0;
            tmp_z          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            zero_q         <= 1'b0;
            carry_q        <= 1'b0;
            for (int i = 0; i < NREG; i++) r[i] <= '0;
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.InValid) begin
                        ir    <= bus.In;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    tmp_res <= alu_res;
                    tmp_c   <= alu_c;
                    tmp_z   <= (alu_res == '0);
                    state   <= WB;
                end
                WB: begin
                    if (op >= 4'd1 && op <= 4'd12) r[rd] <= tmp_res;
                    if (op >= 4'd3 && op <= 4'd13) zero_q <= tmp_z;
                    if (op == 4'd3 || op == 4'd4 || op == 4'd5 || op == 4'd10 ||
                        op == 4'd11 || op == 4'd13) carry_q <= tmp_c;
                    if (op == 4'd14) begin
                        result_q       <= tmp_res;
                        result_valid_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.InReady     = (state == IDLE);
    assign bus.Busy        = (state != IDLE);
    assign bus.Result      = result_q;
    assign bus.ResultValid = result_valid_q;
    assign bus.Zero        = zero_q;
    assign bus.Carry       = carry_q;
endmodule

// File: tb/tb_tiny_cpu_gen2.sv
// tb/tb_tiny_cpu_gen2.sv - directed self-checking bench for tiny_cpu_gen2
module tb_tiny_cpu_gen2;
    logic Clk = 1'b0;
    logic Clear;
    int   checks = 0;
    int   errors = 0;
    int   acc;

    always #5 Clk = ~Clk;

    tiny_cpu_gen2_if #(.W(8),  .NREG(4)) bus ();
    tiny_cpu_gen2_if #(.W(16), .NREG(8)) bus16 ();

    tiny_cpu_gen2 #(.W(8),  .NREG(4)) dut   (.Clk(Clk), .Clear(Clear), .bus(bus));
    tiny_cpu_gen2 #(.W(16), .NREG(8)) dut16 (.Clk(Clk), .Clear(Clear), .bus(bus16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] imm);
        int n = 0;
        while (!bus.InReady && n < 10) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("ready_before_issue", {31'b0, bus.InReady}, 32'd1);
        bus.In      = {op, rd, rs, imm};
        bus.InValid = 1'b1;
        @(posedge Clk); #1;
        bus.InValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic exec16(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [15:0] imm);
        int n = 0;
        while (!bus16.InReady && n < 10) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("ready16_before_issue", {31'b0, bus16.InReady}, 32'd1);
        bus16.In      = {op, rd, rs, imm};
        bus16.InValid = 1'b1;
        @(posedge Clk); #1;
        bus16.InValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    initial begin
        Clear         = 1'b1;
        bus.In        = '0;
        bus.InValid   = 1'b0;
        bus16.In      = '0;
        bus16.InValid = 1'b0;
        #2;
        chk("rst_inready", {31'b0, bus.InReady}, 32'd1);
        chk("rst_busy",    {31'b0, bus.Busy}, 32'd0);
        chk("rst_result",  {24'b0, bus.Result}, 32'h00);
        chk("rst_rvalid",  {31'b0, bus.ResultValid}, 32'd0);
        chk("rst_flags",   {30'b0, bus.Zero, bus.Carry}, 32'd0);
        @(posedge Clk); #1;
        Clear = 1'b0;

        // Abort LDI r0,0x55 while in EXEC
        bus.In = {4'd1, 2'd0, 2'd0, 8'h55};
        bus.InValid = 1'b1;
        @(posedge Clk); #1;
        bus.InValid = 1'b0;
        chk("exec_busy", {31'b0, bus.Busy}, 32'd1);
        Clear = 1'b1;
        #1;
        chk("abort_inready", {31'b0, bus.InReady}, 32'd1);
        chk("abort_busy",    {31'b0, bus.Busy}, 32'd0);
        @(posedge Clk); #1;
        Clear = 1'b0;
        bus.In = {4'd14, 2'd0, 2'd0, 8'h00};
        bus.InValid = 1'b1;
        @(posedge Clk); #1;
        bus.InValid = 1'b0;
        chk("post_clear_accept", {31'b0, bus.Busy}, 32'd1);
        repeat (2) @(posedge Clk);
        #1;
        chk("abort_r0", {24'b0, bus.Result}, 32'h00);
        chk("abort_rv", {31'b0, bus.ResultValid}, 32'd1);

        // Load / out timing
        exec(4'd1, 2'd2, 2'd0, 8'hA5);
        chk("ldi_no_rv", {31'b0, bus.ResultValid}, 32'd0);
        bus.In = {4'd14, 2'd0, 2'd2, 8'h00};
        bus.InValid = 1'b1;
        @(posedge Clk); #1;
        bus.InValid = 1'b0;
        @(posedge Clk); #1;
        chk("out_rv_early", {31'b0, bus.ResultValid}, 32'd0);
        @(posedge Clk); #1;
        chk("out_result", {24'b0, bus.Result}, 32'hA5);
        chk("out_rv",     {31'b0, bus.ResultValid}, 32'd1);
        @(posedge Clk); #1;
        chk("out_rv_drop", {31'b0, bus.ResultValid}, 32'd0);
        chk("out_hold",    {24'b0, bus.Result}, 32'hA5);

        // Carry chain
        exec(4'd1, 2'd0, 2'd0, 8'hFF);
        exec(4'd1, 2'd1, 2'd0, 8'h01);
        exec(4'd3, 2'd0, 2'd1, 8'h00);
        chk("add_cz", {30'b0, bus.Carry, bus.Zero}, 32'b11);
        exec(4'd14, 2'd0, 2'd0, 8'h00);
        chk("add_r0", {24'b0, bus.Result}, 32'h00);
        exec(4'd1, 2'd2, 2'd0, 8'h00);
        chk("ldi_keeps_c", {31'b0, bus.Carry}, 32'd1);
        exec(4'd4, 2'd2, 2'd2, 8'h00);
        chk("adc_cz", {30'b0, bus.Carry, bus.Zero}, 32'b00);
        exec(4'd14, 2'd0, 2'd2, 8'h00);
        chk("adc_r2", {24'b0, bus.Result}, 32'h01);

        // Compare / shift / logic
        exec(4'd1, 2'd0, 2'd0, 8'h03);
        exec(4'd1, 2'd1, 2'd0, 8'h05);
        exec(4'd13, 2'd0, 2'd1, 8'h00);
        chk("cmp_cz", {30'b0, bus.Carry, bus.Zero}, 32'b10);
        exec(4'd14, 2'd0, 2'd0, 8'h00);
        chk("cmp_r0", {24'b0, bus.Result}, 32'h03);
        exec(4'd1, 2'd3, 2'd0, 8'h81);
        exec(4'd10, 2'd3, 2'd0, 8'h00);
        chk("shl_cz", {30'b0, bus.Carry, bus.Zero}, 32'b10);
        exec(4'd14, 2'd0, 2'd3, 8'h00);
        chk("shl_r3", {24'b0, bus.Result}, 32'h02);
        exec(4'd11, 2'd0, 2'd0, 8'h00);
        exec(4'd14, 2'd0, 2'd0, 8'h00);
        chk("shr_r0", {24'b0, bus.Result}, 32'h01);
        chk("shr_c",  {31'b0, bus.Carry}, 32'd1);
        exec(4'd8, 2'd1, 2'd1, 8'h00);
        chk("xor_cz", {30'b0, bus.Carry, bus.Zero}, 32'b11);
        exec(4'd1, 2'd1, 2'd0, 8'h0F);
        exec(4'd9, 2'd1, 2'd1, 8'h00);
        exec(4'd14, 2'd0, 2'd1, 8'h00);
        chk("nand_r1", {24'b0, bus.Result}, 32'hF0);
        chk("nand_z",  {31'b0, bus.Zero}, 32'd0);

        // Continuous InValid: one accept per 3 cycles, busy-time changes ignored
        acc = 0;
        bus.In = {4'd1, 2'd1, 2'd0, 8'h11};
        bus.InValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (bus.InReady) acc++;
            @(posedge Clk); #1;
            if (i == 0) bus.In = {4'd1, 2'd1, 2'd0, 8'h99};
            if (i == 1) bus.In = {4'd1, 2'd1, 2'd0, 8'h22};
        end
        bus.InValid = 1'b0;
        chk("accept_count", acc, 32'd3);
        exec(4'd14, 2'd0, 2'd1, 8'h00);
        chk("busy_change_ignored", {24'b0, bus.Result}, 32'h22);

        // Wide configuration
        exec16(4'd1, 3'd0, 3'd0, 16'hFFFF);
        exec16(4'd1, 3'd1, 3'd0, 16'h0001);
        exec16(4'd3, 3'd0, 3'd1, 16'h0000);
        chk("w16_add_cz", {30'b0, bus16.Carry, bus16.Zero}, 32'b11);
        exec16(4'd14, 3'd0, 3'd0, 16'h0000);
        chk("w16_add_r0", {16'b0, bus16.Result}, 32'h0000);
        exec16(4'd1, 3'd7, 3'd0, 16'hBEEF);
        exec16(4'd14, 3'd0, 3'd7, 16'h0000);
        chk("w16_out_r7", {16'b0, bus16.Result}, 32'hBEEF);
        chk("w16_rv",     {31'b0, bus16.ResultValid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tiny_cpu_gen2.md
TINY_CPU_GEN2 -- requirements
Module: tiny_cpu_gen2

Interface
REQ-001 SHALL have parameter W, default 8: data/register width in bits, 4 to 32.
REQ-002 SHALL have parameter NREG, default 4: number of general registers, a power of 2 from 2 to 16. RA = clog2(NREG).
REQ-003 SHALL have derived width IW = 4 + 2*RA + W, which is 16 at the defaults.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: Clk and Clear.
REQ-005 Clk  input  1  clock; all state updates on the rising edge.
REQ-006 Clear  input  1  asynchronous active-high reset.
REQ-007 In  input  IW  instruction word:
- op = In[IW-1:IW-4]
- rd = next RA bits
- rs = next RA bits
- imm = In[W-1:0]
REQ-008 InValid  input  1  In holds a valid instruction.
REQ-009 InReady  output  1  block can accept an instruction this cycle.
REQ-010 Result  output  W  output register.
REQ-011 ResultValid  output  1  one-cycle pulse marking a Result update.
REQ-012 Zero, Carry  output  1 each  status flags.
REQ-013 Busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement a three-state FSM IDLE -> EXEC -> WB -> IDLE, with no other transitions.
REQ-015 InReady SHALL be 1 only in IDLE.
REQ-016 An instruction is accepted on an edge where InValid and InReady are both 1. The edge latches In into an internal instruction register and moves to EXEC.
REQ-017 InValid while not IDLE SHALL be ignored. The sender holds the instruction until accepted.
REQ-018 In EXEC, the ALU result and next-flag values SHALL be computed from registers R[rd] and R[rs] and captured into a temporary register. The state moves to WB.
REQ-019 On the edge leaving WB, the destination register, flags and Result SHALL update per opcode. Architectural effects are visible 3 edges after the accept edge; throughput is one instruction per 3 cycles.
REQ-020 Opcodes (arithmetic is modulo 2^W; "Z" means Zero = (result == 0)):
- 0 NOP.
- 1 LDI: R[rd] = imm.
- 2 MOV: R[rd] = R[rs].
- 3 ADD: R[rd] = R[rd] + R[rs]; Carry = carry-out; Z.
- 4 ADC: as ADD, plus the current Carry.
- 5 SUB: R[rd] = R[rd] - R[rs]; Carry = 1 iff R[rd] < R[rs] unsigned; Z.
- 6 AND, 7 OR, 8 XOR, 9 NAND: R[rd] = R[rd] op R[rs]; Z; Carry unchanged.
- 10 SHL: R[rd] = R[rd] << 1; Carry = old MSB; Z.
- 11 SHR: R[rd] = R[rd] >> 1 (logical); Carry = old LSB; Z.
- 12 NOT: R[rd] = ~R[rd]; Z.
- 13 CMP: flags as SUB; no register write.
- 14 OUT: Result = R[rs]; ResultValid = 1 for exactly the cycle after the WB edge.
- 15 reserved: behaves as NOP.
REQ-021 Flags SHALL be changed only by the opcodes listed as setting them.
REQ-022 Operands SHALL be read in EXEC. rd == rs is legal and uses the same value for both operands (e.g. ADD r1,r1 doubles r1).
REQ-023 ResultValid SHALL be 0 in every cycle except the one following an OUT write-back. Result SHALL hold its value until the next OUT.
REQ-024 Busy SHALL equal (state != IDLE).
REQ-025 No combinational path SHALL exist from In or InValid to any output except InReady, which depends on state only.

Reset
REQ-026 While Clear = 1, the block SHALL immediately (asynchronously) hold:
- all R[i] = 0, Result = 0, ResultValid = 0
- Zero = 0, Carry = 0
- state = IDLE, Busy = 0, InReady = 1
REQ-027 Clear asserted in EXEC or WB SHALL abort the instruction with no register, flag or Result update.
REQ-028 After Clear deasserts, the first rising edge with InValid = 1 SHALL accept.

Verification
REQ-029 Reset: Clear pulse mid-EXEC of LDI r0,0x55 -> r0 stays 0x00, Result 0x00, InReady 1 immediately.
REQ-030 Load/out (defaults): LDI r2,0xA5 then OUT rs=r2 -> Result 0xA5 and ResultValid high exactly one cycle, 3 edges after the OUT accept.
REQ-031 Carry chain: r0 = 0xFF, r1 = 0x01; ADD r0,r1 -> r0 0x00, Carry 1, Zero 1. Then ADC r2,r2 with r2 = 0 -> r2 0x01, Carry 0.
REQ-032 Handshake: InValid held high continuously with distinct instructions -> exactly one accept per 3 cycles; an instruction changed while Busy = 1 is never executed.
REQ-033 Compare/shift: r0 = 0x03, r1 = 0x05; CMP r0,r1 -> Carry 1, Zero 0, r0 unchanged. SHL on 0x81 -> 0x02, Carry 1.
REQ-034 Parameter sweep: W = 16, NREG = 8 (IW = 26); ADD 0xFFFF + 0x0001 -> 0x0000, Carry 1; LDI r7 / OUT r7 round-trips.
